// File: rtl/signed_mult_seq_if.sv
// Handshake bundle for signed_mult_seq.
//   start   : request, sampled only while ready is high
//   a, b    : WIDTH-bit two's-complement operands
//   ready   : block is idle and will accept start
//   done    : one-cycle pulse, product valid
//   product : 2*WIDTH+1-bit two's-complement result, held until the next done
// master drives the request side, slave is the multiplier.
interface signed_mult_seq_if #(
  parameter int WIDTH = 12
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 ready;
  logic                 done;
  logic [2*WIDTH:0]     product;

  modport master (
    output start, a, b,
    input  ready, done, product
  );

  modport slave (
    input  start, a, b,
    output ready, done, product
  );
endinterface

// File: rtl/signed_mult_seq.sv
// signed_mult_seq: sequential signed multiplier, one shift-add per cycle.
// Operands are converted to magnitudes, multiplied unsigned over WIDTH cycles,
// then the widened magnitude is negated when the operand signs differ.
// Latency from accept edge to done is WIDTH+2 edges.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; aborts any in-flight operation
//   bus   : signed_mult_seq_if slave (start, a, b, ready, done, product)
module signed_mult_seq #(
  parameter int WIDTH = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  signed_mult_seq_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ABS  = 2'd1;
  localparam logic [1:0] MUL  = 2'd2;
  localparam logic [1:0] FIX  = 2'd3;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0]      LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      ONE_C = CW'(1);
  localparam logic [WIDTH-1:0]   ONE_W = WIDTH'(1);
  localparam logic [2*WIDTH:0]   ONE_P = (2*WIDTH+1)'(1);

  logic [1:0]         state;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic               sign_r;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;
  logic [2*WIDTH:0]   product_r;
  logic               done_r;

  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH:0]   ext;

  // Partial product for the current iteration: mag_a weighted by the bit
  // position, gated by the multiplier bit that has been shifted into mag_b[0].
  always_comb begin
    // NOTE: default first so every path assigns addend and no latch is inferred.
    addend = '0;
    if (mag_b[0]) begin
      addend = {{WIDTH{1'b0}}, mag_a} << count;
    end
  end

  // One extra bit so negating the largest magnitude cannot overflow.
  assign ext = {1'b0, acc};

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every register, datapath included, is reset so an aborted
      // operation leaves no residue and product reads 0 after reset.
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      sign_r    <= 1'b0;
      mag_a     <= '0;
      mag_b     <= '0;
      acc       <= '0;
      count     <= '0;
      product_r <= '0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_r    <= bus.a;
            b_r    <= bus.b;
            sign_r <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            state  <= ABS;
          end
        end
        ABS: begin
          // -2^(WIDTH-1) negates to itself, which read unsigned is the
          // correct magnitude 2^(WIDTH-1).
          mag_a <= a_r[WIDTH-1] ? (~a_r + ONE_W) : a_r;
          mag_b <= b_r[WIDTH-1] ? (~b_r + ONE_W) : b_r;
          acc   <= '0;
          count <= '0;
          state <= MUL;
        end
        MUL: begin
          acc   <= acc + addend;
          mag_b <= mag_b >> 1;
          count <= count + ONE_C;
          if (count == LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          // Negating zero yields zero, so there is no negative zero.
          product_r <= sign_r ? (~ext + ONE_P) : ext;
          done_r    <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready   = (state == IDLE);
  assign bus.done    = done_r;
  assign bus.product = product_r;

endmodule

// File: tb/tb_signed_mult_seq.sv
// Directed self-checking bench for signed_mult_seq (WIDTH=12, 25-bit result).
module tb_signed_mult_seq;

  localparam int WIDTH   = 12;
  localparam int LATENCY = WIDTH + 2;
  localparam int BOUND   = 60;

  logic clk;
  logic rst_n;

  int errors = 0;
  int checks = 0;

  signed_mult_seq_if #(.WIDTH(WIDTH)) bus ();

  signed_mult_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called on the negedge after the accept edge. Advances one cycle at a time
  // until done is seen or the bound expires; lat = -1 on timeout.
  // early_ready is set if ready was high in any cycle before done.
  task automatic wait_done(output int lat, output bit early_ready);
    lat = -1;
    early_ready = 1'b0;
    if (bus.ready === 1'b1) early_ready = 1'b1;
    for (int n = 1; n <= BOUND; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = n;
        break;
      end
      if (bus.ready !== 1'b0) early_ready = 1'b1;
    end
  endtask

  // Issue a single request, then check handshake, latency, result, pulse width.
  task automatic run_op(input string name, input logic [WIDTH-1:0] av,
                        input logic [WIDTH-1:0] bv, input logic [2*WIDTH:0] exp);
    int lat;
    bit early;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    wait_done(lat, early);
    checks++;
    if (early !== 1'b0) begin
      errors++;
      $display("FAIL %s ready_busy: ready seen high while busy, expected low", name);
    end
    checks++;
    if (lat !== LATENCY) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, LATENCY);
    end
    checks++;
    if (bus.product !== exp) begin
      errors++;
      $display("FAIL %s product: got %h expected %h", name, bus.product, exp);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.product !== exp) begin
      errors++;
      $display("FAIL %s done_pulse: done=%b product=%h expected done=0 product=%h",
               name, bus.done, bus.product, exp);
    end
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", bus.ready);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b expected 0", bus.done);
    end
    checks++;
    if (bus.product !== 25'h0000000) begin
      errors++;
      $display("FAIL reset_product: got %h expected 0000000", bus.product);
    end
  endtask

  task automatic test_pos_pos;
    run_op("pos_3x5", 12'd3, 12'd5, 25'h000000F);
  endtask

  task automatic test_mixed_signs;
    run_op("neg7x9", 12'hFF9, 12'd9, 25'h1FFFFC1);
    run_op("2047xneg1", 12'd2047, 12'hFFF, 25'h1FFF801);
  endtask

  task automatic test_corners;
    run_op("min_x_min", 12'h800, 12'h800, 25'h0400000);
    run_op("min_x_max", 12'h800, 12'd2047, 25'h1C00800);
    run_op("zero_x_neg5", 12'd0, 12'hFFB, 25'h0000000);
  endtask

  // A start during busy is ignored; a start in the done cycle is accepted.
  task automatic test_back_to_back;
    int lat;
    bit early;
    int pulses;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 12'd2;
    bus.b     = 12'd3;
    @(negedge clk);
    bus.a = 12'd4;
    bus.b = 12'd4;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
    bus.start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        pulses++;
        if (pulses == 1) begin
          checks++;
          if (bus.product !== 25'h0000006) begin
            errors++;
            $display("FAIL busy_ignore_product: got %h expected 0000006", bus.product);
          end
        end
      end
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL busy_ignore_pulses: got %0d done pulses expected 1", pulses);
    end
    checks++;
    if (bus.product !== 25'h0000006) begin
      errors++;
      $display("FAIL busy_ignore_hold: got %h expected 0000006", bus.product);
    end

    // Start again and issue the next request in the very cycle done is high.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 12'd1;
    bus.b     = 12'd7;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat, early);
    checks++;
    if (lat !== LATENCY || bus.product !== 25'h0000007) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d product=%h expected lat=%0d product=0000007",
               lat, bus.product, LATENCY);
    end
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_in_done: got %b expected 1", bus.ready);
    end
    bus.start = 1'b1;
    bus.a     = 12'd4;
    bus.b     = 12'd4;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat, early);
    checks++;
    if (lat !== LATENCY || bus.product !== 25'h0000010) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d product=%h expected lat=%0d product=0000010",
               lat, bus.product, LATENCY);
    end
  endtask

  task automatic test_reset_mid_op;
    int pulses;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 12'd100;
    bus.b     = 12'd100;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.product !== 25'h0000000 || bus.ready !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_state: product=%h ready=%b done=%b expected 0000000 1 0",
               bus.product, bus.ready, bus.done);
    end
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0 || bus.product !== 25'h0000000) begin
      errors++;
      $display("FAIL mid_reset_no_done: pulses=%0d product=%h expected 0 0000000",
               pulses, bus.product);
    end
    run_op("after_reset_1x1", 12'd1, 12'd1, 25'h0000001);
  endtask

  initial begin
    test_reset();
    test_pos_pos();
    test_mixed_signs();
    test_corners();
    test_back_to_back();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
